// File: rtl/simon_pkg.sv
// Shared types, default constants and the Galois LFSR step function for the
// Simon sequence generator.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } simon_state_e;

    localparam int          SIMON_LFSR_W = 16;
    localparam int          SIMON_SYM_W  = 2;
    localparam logic [15:0] SIMON_TAPS   = 16'hB400;

    // Widest LFSR the step function handles; callers zero-extend into it.
    localparam int          SIMON_MAX_W  = 64;

    function automatic logic [SIMON_MAX_W-1:0] lfsr_next(
        input logic [SIMON_MAX_W-1:0] state,
        input logic [SIMON_MAX_W-1:0] taps
    );
        lfsr_next = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Parametrised right-shifting Galois LFSR; load has priority over step and
// only the low SYM_W bits are exposed as the candidate symbol.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int             W     = SIMON_LFSR_W,
    parameter int             SYM_W = SIMON_SYM_W,
    parameter logic [W-1:0]   TAPS  = W'(SIMON_TAPS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             step,
    output logic [SYM_W-1:0] sym
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = W'(lfsr_next(64'(state_q), 64'(TAPS)));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign sym = state_q[SYM_W-1:0];

endmodule

// File: rtl/simon_sequence_generator.sv
// Simon colour-sequence generator: seeds an LFSR from a free-running counter
// and replays a growing round as a valid/ready symbol stream.
// Optional build macro SIMON_SEQ_NO_REPEAT_EN suppresses immediate repeats.
//
// state | meaning
// IDLE  | after reset, no seed captured yet
// ARMED | seed and round length set, waiting for replay
// PLAY  | streaming symbols 0..round_len-1
// DONE  | round fully accepted, waiting for replay or next_round
module simon_sequence_generator
    import simon_pkg::*;
#(
    parameter int                LFSR_W  = SIMON_LFSR_W,
    parameter int                SYM_W   = SIMON_SYM_W,
    parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(SIMON_TAPS),
    parameter int                MAX_LEN = 32,
    localparam int               IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             replay,
    input  logic             next_round,
    input  logic             sym_ready,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_data,
    output logic [IDX_W-1:0] sym_index,
    output logic [IDX_W-1:0] round_len,
    output logic             seq_done,
    output logic             max_reached
);

    simon_state_e      state_q, state_d;
    logic [LFSR_W-1:0] free_cnt_q, free_cnt_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [IDX_W-1:0]  round_len_q, round_len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              max_q, max_d;

    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic              lfsr_step;
    logic [SYM_W-1:0]  lfsr_sym;
    logic [SYM_W-1:0]  sym_emit;
    logic [LFSR_W-1:0] start_seed;
    logic              accept;
    logic              last;

`ifdef SIMON_SEQ_NO_REPEAT_EN
    logic [SYM_W-1:0]  prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
`endif

    simon_lfsr #(
        .W     (LFSR_W),
        .SYM_W (SYM_W),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .sym      (lfsr_sym)
    );

    // An all-zero seed would lock the LFSR, so a zero count seeds with 1.
    assign start_seed = (free_cnt_q == '0) ? LFSR_W'(1) : free_cnt_q;
    assign accept     = (state_q == PLAY) && sym_ready;
    assign last       = (idx_q == round_len_q - IDX_W'(1));

    always_comb begin
        sym_emit = lfsr_sym;
`ifdef SIMON_SEQ_NO_REPEAT_EN
        if (prev_vld_q && (lfsr_sym == prev_q)) begin
            sym_emit = lfsr_sym + SYM_W'(1);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            free_cnt_q  <= '0;
            seed_q      <= '0;
            round_len_q <= '0;
            idx_q       <= '0;
            max_q       <= 1'b0;
`ifdef SIMON_SEQ_NO_REPEAT_EN
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            free_cnt_q  <= free_cnt_d;
            seed_q      <= seed_d;
            round_len_q <= round_len_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
`ifdef SIMON_SEQ_NO_REPEAT_EN
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        free_cnt_d    = free_cnt_q + LFSR_W'(1);
        seed_d        = seed_q;
        round_len_d   = round_len_q;
        idx_d         = idx_q;
        max_d         = max_q;
        lfsr_load     = 1'b0;
        lfsr_load_val = seed_q;
        lfsr_step     = 1'b0;
`ifdef SIMON_SEQ_NO_REPEAT_EN
        prev_d        = prev_q;
        prev_vld_d    = prev_vld_q;
`endif
        if (start) begin
            seed_d        = start_seed;
            lfsr_load     = 1'b1;
            lfsr_load_val = start_seed;
            round_len_d   = IDX_W'(1);
            idx_d         = '0;
            max_d         = 1'b0;
            state_d       = ARMED;
`ifdef SIMON_SEQ_NO_REPEAT_EN
            prev_vld_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ARMED, DONE: begin
                    if (replay) begin
                        lfsr_load = 1'b1;
                        idx_d     = '0;
                        state_d   = PLAY;
`ifdef SIMON_SEQ_NO_REPEAT_EN
                        prev_vld_d = 1'b0;
`endif
                    end else if (next_round && (state_q == DONE)) begin
                        if (round_len_q < IDX_W'(MAX_LEN)) begin
                            round_len_d = round_len_q + IDX_W'(1);
                            state_d     = ARMED;
                        end else begin
                            max_d = 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (accept) begin
                        lfsr_step = 1'b1;
`ifdef SIMON_SEQ_NO_REPEAT_EN
                        prev_d     = sym_emit;
                        prev_vld_d = 1'b1;
`endif
                        if (last) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sym_valid   = (state_q == PLAY);
        sym_data    = sym_valid ? sym_emit : '0;
        sym_index   = idx_q;
        round_len   = round_len_q;
        max_reached = max_q;
        // A start that aborts the stream must not report completion.
        seq_done    = accept && last && !start;
    end

endmodule

// File: tb/tb_simon_sequence_generator.sv
// Directed bench for simon_sequence_generator built with MAX_LEN = 3.
module tb_simon_sequence_generator;

    localparam int IDX_W = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start, replay, next_round, sym_ready;
    logic             sym_valid;
    logic [1:0]       sym_data;
    logic [IDX_W-1:0] sym_index;
    logic [IDX_W-1:0] round_len;
    logic             seq_done;
    logic             max_reached;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] fc_model;
    logic [15:0] exp_seed;
    logic [1:0]  exp_seq [3];

    simon_sequence_generator #(.MAX_LEN(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .replay      (replay),
        .next_round  (next_round),
        .sym_ready   (sym_ready),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_index   (sym_index),
        .round_len   (round_len),
        .seq_done    (seq_done),
        .max_reached (max_reached)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) fc_model <= '0;
        else          fc_model <= fc_model + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Replays the round and drains it with sym_ready held high.
    task automatic play_round(input int n);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        sym_ready = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("play_valid", sym_valid, 1);
            chk("play_index", sym_index, i);
            chk("play_data", sym_data, exp_seq[i]);
            chk("play_done", seq_done, (i == n - 1));
            tick();
        end
        sym_ready = 1'b0;
        #1;
        chk("play_end_valid", sym_valid, 0);
        chk("play_end_done", seq_done, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 0; replay = 0; next_round = 0; sym_ready = 0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b00;
`ifdef SIMON_SEQ_NO_REPEAT_EN
        exp_seq[2] = 2'b01;
`else
        exp_seq[2] = 2'b00;
`endif
        #2;
        chk("rst_valid", sym_valid, 0);
        chk("rst_data", sym_data, 0);
        chk("rst_index", sym_index, 0);
        chk("rst_len", round_len, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_max", max_reached, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // zero free count at the first edge -> seed 1
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_len", round_len, 1);
        chk("start_valid", sym_valid, 0);
        play_round(1);

        next_round = 1'b1;
        tick();
        next_round = 1'b0;
        chk("r2_len", round_len, 2);
        play_round(2);

        next_round = 1'b1;
        tick();
        next_round = 1'b0;
        chk("r3_len", round_len, 3);
        play_round(3);

        // round 3 again with 4 stalled cycles on index 1
        replay = 1'b1;
        tick();
        replay = 1'b0;
        sym_ready = 1'b1;
        #1;
        chk("bp_d0", sym_data, exp_seq[0]);
        tick();
        sym_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", sym_valid, 1);
            chk("bp_index", sym_index, 1);
            chk("bp_data", sym_data, exp_seq[1]);
        end
        sym_ready = 1'b1;
        #1;
        chk("bp_d1", sym_data, exp_seq[1]);
        tick();
        chk("bp_i2", sym_index, 2);
        chk("bp_d2", sym_data, exp_seq[2]);
        chk("bp_last_done", seq_done, 1);
        tick();
        sym_ready = 1'b0;
        #1;
        chk("bp_end_valid", sym_valid, 0);

        // saturation at MAX_LEN = 3
        next_round = 1'b1;
        tick();
        next_round = 1'b0;
        chk("sat_len", round_len, 3);
        chk("sat_max", max_reached, 1);
        chk("sat_valid", sym_valid, 0);

        // replay beats next_round
        replay = 1'b1; next_round = 1'b1;
        tick();
        replay = 1'b0; next_round = 1'b0;
        chk("pri_len", round_len, 3);
        chk("pri_valid", sym_valid, 1);
        chk("pri_index", sym_index, 0);

        // abort with start at index 1
        sym_ready = 1'b1;
        tick();
        chk("abort_idx", sym_index, 1);
        start = 1'b1;
        exp_seed = (fc_model == 16'd0) ? 16'd1 : fc_model;
        #1;
        chk("abort_no_done", seq_done, 0);
        tick();
        start = 1'b0; sym_ready = 1'b0;
        chk("abort_valid", sym_valid, 0);
        chk("abort_len", round_len, 1);
        chk("abort_max", max_reached, 0);
        chk("abort_done", seq_done, 0);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        chk("abort_seed_sym", sym_data, exp_seed[1:0]);
        chk("abort_seed_valid", sym_valid, 1);

        // async reset mid-PLAY, between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("ares_valid", sym_valid, 0);
        chk("ares_data", sym_data, 0);
        chk("ares_len", round_len, 0);
        start = 1'b1;
        tick();
        tick();
        chk("ares_start_len", round_len, 0);
        chk("ares_start_valid", sym_valid, 0);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rec_len", round_len, 1);
        play_round(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
